// File: rtl/gpio_regbank_irq.sv
// rtl/gpio_regbank_irq.sv - GPIO direction/open-drain/mux register bank with synchronised inputs and edge interrupt
module gpio_regbank_irq #(
  parameter int NumGPIO      = 2,
  parameter int GPIOWidth    = 36,
  parameter int BusWidth     = 32,
  parameter int AddrWidth    = 16,
  parameter int PortNumWidth = 8,
  parameter int SyncStages   = 2
) (
  input  logic                                    reg_clk,
  input  logic                                    reset_reg_N,
  input  logic                                    chip_sel,
  input  logic                                    write_reg,
  input  logic                                    read_reg,
  input  logic [AddrWidth-3:0]                    busaddress,
  input  logic [BusWidth-1:0]                     busdata_in,
  input  logic [BusWidth-1:0]                     busdata_fromhm2,
  input  logic [NumGPIO*GPIOWidth-1:0]            pin_in,
  output logic [BusWidth-1:0]                     busdata_out,
  output logic [NumGPIO*GPIOWidth-1:0]            oe_out,
  output logic [NumGPIO*GPIOWidth-1:0]            od_out,
  output logic [NumGPIO*GPIOWidth*PortNumWidth-1:0] portsel_out,
  output logic                                    irq
);

  localparam int N  = NumGPIO * GPIOWidth;
  localparam int NW = (N + BusWidth - 1) / BusWidth;

  localparam logic [2:0] PG_DDR  = 3'd1;
  localparam logic [2:0] PG_MUX  = 3'd2;
  localparam logic [2:0] PG_OD   = 3'd3;
  localparam logic [2:0] PG_IN   = 3'd4;
  localparam logic [2:0] PG_RISE = 3'd5;
  localparam logic [2:0] PG_FALL = 3'd6;
  localparam logic [2:0] PG_STAT = 3'd7;

  logic [AddrWidth-1:0] byte_addr;
  logic                 in_window;
  logic [2:0]           page;
  logic [5:0]           widx;

  assign byte_addr = {busaddress, 2'b00};
  assign in_window = (byte_addr >= AddrWidth'(16'h1100)) && (byte_addr <= AddrWidth'(16'h17FF));
  assign page      = byte_addr[10:8];
  assign widx      = busaddress[5:0];

  // Writes are staged one cycle so a read on the same edge still sees the old contents.
  logic                wr_pend;
  logic [2:0]          wr_page;
  logic [5:0]          wr_idx;
  logic [BusWidth-1:0] wr_data;
  logic [N-1:0]        wr_mask;
  logic [N-1:0]        wr_bits;

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      wr_pend <= 1'b0;
      wr_page <= '0;
      wr_idx  <= '0;
      wr_data <= '0;
    end else begin
      wr_pend <= chip_sel & write_reg & in_window;
      wr_page <= page;
      wr_idx  <= widx;
      wr_data <= busdata_in;
    end
  end

  always_comb begin
    wr_mask = '0;
    wr_bits = '0;
    for (int p = 0; p < N; p++) begin
      if (int'(wr_idx) == p / BusWidth) begin
        wr_mask[p] = 1'b1;
        wr_bits[p] = wr_data[p % BusWidth];
      end
    end
  end

  logic [N-1:0]            ddr_q, od_q, rise_en_q, fall_en_q, status_q;
  logic [PortNumWidth-1:0] mux_q [N];

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      ddr_q     <= '0;
      od_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      for (int p = 0; p < N; p++) mux_q[p] <= PortNumWidth'(p);
    end else if (wr_pend) begin
      if (wr_page == PG_DDR)  ddr_q     <= (ddr_q     & ~wr_mask) | wr_bits;
      if (wr_page == PG_OD)   od_q      <= (od_q      & ~wr_mask) | wr_bits;
      if (wr_page == PG_RISE) rise_en_q <= (rise_en_q & ~wr_mask) | wr_bits;
      if (wr_page == PG_FALL) fall_en_q <= (fall_en_q & ~wr_mask) | wr_bits;
      if (wr_page == PG_MUX) begin
        for (int p = 0; p < N; p++) begin
          if (int'(wr_idx) == p / 4) mux_q[p] <= wr_data[8*(p%4) +: PortNumWidth];
        end
      end
    end
  end

  logic [N-1:0] sync_q [SyncStages];
  logic [N-1:0] prev_q;
  logic [N-1:0] sync_w, rise_w, fall_w, clear_w;

  assign sync_w  = sync_q[SyncStages-1];
  assign rise_w  = sync_w & ~prev_q & rise_en_q;
  assign fall_w  = ~sync_w & prev_q & fall_en_q;
  assign clear_w = (wr_pend && (wr_page == PG_STAT)) ? wr_bits : '0;

  // A new event wins over a simultaneous write-1-to-clear.
  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      for (int i = 0; i < SyncStages; i++) sync_q[i] <= '0;
      prev_q   <= '0;
      status_q <= '0;
      irq      <= 1'b0;
    end else begin
      sync_q[0] <= pin_in;
      for (int i = 1; i < SyncStages; i++) sync_q[i] <= sync_q[i-1];
      prev_q   <= sync_w;
      status_q <= (status_q & ~clear_w) | rise_w | fall_w;
      irq      <= |status_q;
    end
  end

  function automatic logic [BusWidth-1:0] pick(input logic [N-1:0] v, input logic [5:0] idx);
    logic [NW*BusWidth-1:0] pad;
    pad        = '0;
    pad[N-1:0] = v;
    pick       = '0;
    for (int k = 0; k < NW; k++) begin
      if (int'(idx) == k) pick = pad[k*BusWidth +: BusWidth];
    end
  endfunction

  // Read pipeline: address at the accept edge, register data one edge later, output the edge after.
  logic                rd_v1, rd_win1, rd_v2;
  logic [2:0]          rd_page1;
  logic [5:0]          rd_idx1;
  logic [BusWidth-1:0] rd_hm2_1, rd_d2, rd_word;

  always_comb begin
    rd_word = '0;
    case (rd_page1)
      PG_DDR:  rd_word = pick(ddr_q, rd_idx1);
      PG_OD:   rd_word = pick(od_q, rd_idx1);
      PG_IN:   rd_word = pick(sync_w, rd_idx1);
      PG_RISE: rd_word = pick(rise_en_q, rd_idx1);
      PG_FALL: rd_word = pick(fall_en_q, rd_idx1);
      PG_STAT: rd_word = pick(status_q, rd_idx1);
      PG_MUX: begin
        for (int p = 0; p < N; p++) begin
          if (int'(rd_idx1) == p / 4) rd_word[8*(p%4) +: PortNumWidth] = mux_q[p];
        end
      end
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      rd_v1       <= 1'b0;
      rd_win1     <= 1'b0;
      rd_page1    <= '0;
      rd_idx1     <= '0;
      rd_hm2_1    <= '0;
      rd_v2       <= 1'b0;
      rd_d2       <= '0;
      busdata_out <= '0;
    end else begin
      rd_v1    <= chip_sel & read_reg;
      rd_win1  <= in_window;
      rd_page1 <= page;
      rd_idx1  <= widx;
      rd_hm2_1 <= busdata_fromhm2;
      rd_v2    <= rd_v1;
      rd_d2    <= rd_win1 ? rd_word : rd_hm2_1;
      if (rd_v2) busdata_out <= rd_d2;
    end
  end

  assign oe_out = ddr_q;
  assign od_out = od_q;

  for (genvar p = 0; p < N; p++) begin : g_portsel
    assign portsel_out[p*PortNumWidth +: PortNumWidth] = mux_q[p];
  end

endmodule

// File: tb/tb_gpio_regbank_irq.sv
// tb/tb_gpio_regbank_irq.sv - scoreboard bench for gpio_regbank_irq
module tb_gpio_regbank_irq;

  localparam int N = 72;

  logic           reg_clk = 1'b0;
  logic           reset_reg_N;
  logic           chip_sel, write_reg, read_reg;
  logic [13:0]    busaddress;
  logic [31:0]    busdata_in, busdata_fromhm2;
  logic [N-1:0]   pin_in;
  logic [31:0]    busdata_out;
  logic [N-1:0]   oe_out, od_out;
  logic [N*8-1:0] portsel_out;
  logic           irq;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [2:0]  rd_sh;

  gpio_regbank_irq dut (
    .reg_clk(reg_clk), .reset_reg_N(reset_reg_N), .chip_sel(chip_sel),
    .write_reg(write_reg), .read_reg(read_reg), .busaddress(busaddress),
    .busdata_in(busdata_in), .busdata_fromhm2(busdata_fromhm2), .pin_in(pin_in),
    .busdata_out(busdata_out), .oe_out(oe_out), .od_out(od_out),
    .portsel_out(portsel_out), .irq(irq)
  );

  always #5 reg_clk = ~reg_clk;

  // Read results are due two edges after the accepting edge.
  always @(posedge reg_clk or negedge reset_reg_N) begin
    if (!reset_reg_N) rd_sh <= '0;
    else              rd_sh <= {rd_sh[1:0], chip_sel & read_reg};
  end

  always @(negedge reg_clk) begin
    if (rd_sh[2]) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rd_extra got=%h expected=none", busdata_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (busdata_out !== mon_exp) begin
          failures++;
          $display("FAIL rd_data got=%h expected=%h", busdata_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  task automatic bus_idle();
    @(negedge reg_clk);
    chip_sel = 0; write_reg = 0; read_reg = 0;
  endtask

  task automatic bus_read(input logic [15:0] a, input logic [31:0] e);
    @(negedge reg_clk);
    chip_sel = 1; read_reg = 1; write_reg = 0; busaddress = a[15:2];
    exp_q.push_back(e);
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge reg_clk);
    chip_sel = 1; write_reg = 1; read_reg = 0; busaddress = a[15:2]; busdata_in = d;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge reg_clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got=%0d pending expected=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    logic [N*8-1:0] exp_ps;
    for (int p = 0; p < N; p++) exp_ps[p*8 +: 8] = 8'(p);
    reset_reg_N = 0; chip_sel = 0; write_reg = 0; read_reg = 0;
    busaddress = '0; busdata_in = '0; busdata_fromhm2 = '0; pin_in = '0;
    repeat (3) @(negedge reg_clk);
    checks++; if (busdata_out !== 32'h0) begin failures++; $display("FAIL rst_busdata got=%h expected=0", busdata_out); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_irq got=%b expected=0", irq); end
    checks++; if (oe_out !== '0) begin failures++; $display("FAIL rst_oe got=%h expected=0", oe_out); end
    checks++; if (od_out !== '0) begin failures++; $display("FAIL rst_od got=%h expected=0", od_out); end
    checks++; if (portsel_out !== exp_ps) begin failures++; $display("FAIL rst_portsel got=%h expected=%h", portsel_out, exp_ps); end
    @(negedge reg_clk);
    reset_reg_N = 1;
    bus_read(16'h1200, 32'h03020100);
    bus_read(16'h1100, 32'h0);
    bus_idle();
    drain("reset");
  endtask

  task automatic test_ddr();
    bus_write(16'h1104, 32'hFFFFFFFF);
    bus_idle();
    checks++; if (oe_out !== '0) begin failures++; $display("FAIL ddr_latency got=%h expected=0", oe_out); end
    @(negedge reg_clk);
    checks++; if (oe_out !== 72'h00_FFFFFFFF_00000000) begin failures++; $display("FAIL ddr_word1 got=%h expected=00ffffffff00000000", oe_out); end
    bus_write(16'h1108, 32'hFFFFFFFF);
    bus_write(16'h110C, 32'hFFFFFFFF);
    bus_idle();
    @(negedge reg_clk);
    checks++; if (oe_out !== 72'hFF_FFFFFFFF_00000000) begin failures++; $display("FAIL ddr_top got=%h expected=ffffffffff00000000", oe_out); end
    bus_read(16'h1104, 32'hFFFFFFFF);
    bus_read(16'h1108, 32'h000000FF);
    bus_read(16'h110C, 32'h0);
    bus_idle();
    drain("ddr");
  endtask

  task automatic test_mux();
    bus_write(16'h1200, 32'h11223344);
    bus_write(16'h1244, 32'hAABBCCDD);
    bus_write(16'h1248, 32'hFFFFFFFF);
    bus_idle();
    @(negedge reg_clk);
    checks++; if (portsel_out[31:0] !== 32'h11223344) begin failures++; $display("FAIL mux_lo got=%h expected=11223344", portsel_out[31:0]); end
    checks++; if (portsel_out[575:544] !== 32'hAABBCCDD) begin failures++; $display("FAIL mux_hi got=%h expected=aabbccdd", portsel_out[575:544]); end
    bus_read(16'h1200, 32'h11223344);
    bus_read(16'h1244, 32'hAABBCCDD);
    bus_read(16'h1248, 32'h0);
    bus_read(16'h1234, 32'h37363534);
    bus_read(16'h1204, 32'h07060504);
    bus_idle();
    drain("mux");
  endtask

  task automatic test_back_to_back();
    pin_in = 72'hA5_12345678_9ABCDEF0;
    repeat (4) @(negedge reg_clk);
    bus_write(16'h1400, 32'h0);
    bus_idle();
    busdata_fromhm2 = 32'hDEADBEEF;
    bus_read(16'h0234, 32'hDEADBEEF);
    bus_read(16'h1400, 32'h9ABCDEF0);
    busdata_fromhm2 = 32'hFEEDFACE;
    bus_read(16'h1404, 32'h12345678);
    bus_read(16'h1408, 32'h000000A5);
    bus_read(16'h2000, 32'hFEEDFACE);
    bus_idle();
    drain("b2b");
  endtask

  task automatic test_od_rw_same_edge();
    bus_write(16'h1300, 32'h5A5A5A5A);
    bus_idle();
    @(negedge reg_clk);
    checks++; if (od_out !== 72'h00_00000000_5A5A5A5A) begin failures++; $display("FAIL od_word0 got=%h expected=5a5a5a5a", od_out); end
    @(negedge reg_clk);
    chip_sel = 1; write_reg = 1; read_reg = 1; busaddress = 14'(16'h1300 >> 2); busdata_in = 32'hFFFF0000;
    exp_q.push_back(32'h5A5A5A5A);
    bus_read(16'h1300, 32'hFFFF0000);
    bus_idle();
    drain("rw");
  endtask

  task automatic test_edge_irq();
    pin_in = '0;
    repeat (4) @(negedge reg_clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_noenable got=%b expected=0", irq); end
    bus_write(16'h1500, 32'h1);
    bus_idle();
    repeat (2) @(negedge reg_clk);
    @(negedge reg_clk);
    pin_in[0] = 1'b1;
    repeat (3) @(negedge reg_clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL edge_irq_early got=%b expected=0", irq); end
    @(negedge reg_clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL edge_irq_set got=%b expected=1", irq); end
    bus_read(16'h1700, 32'h1);
    bus_idle();
    drain("edge");
  endtask

  task automatic test_clear();
    bus_write(16'h1500, 32'h0);
    bus_idle();
    bus_read(16'h1700, 32'h1);
    bus_idle();
    drain("en_clr");
    bus_write(16'h1500, 32'h1);
    bus_idle();
    pin_in[0] = 1'b0;
    repeat (4) @(negedge reg_clk);
    @(negedge reg_clk);
    pin_in[0] = 1'b1;
    bus_write(16'h1700, 32'h1);
    bus_idle();
    @(negedge reg_clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clr_collide_a got=%b expected=1", irq); end
    @(negedge reg_clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clr_collide_b got=%b expected=1", irq); end
    bus_read(16'h1700, 32'h1);
    bus_idle();
    drain("collide");
    bus_write(16'h1700, 32'h1);
    bus_idle();
    @(negedge reg_clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL clr_irq_hold got=%b expected=1", irq); end
    @(negedge reg_clk);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clr_irq_drop got=%b expected=0", irq); end
    bus_read(16'h1700, 32'h0);
    bus_idle();
    drain("clear");
  endtask

  task automatic test_reset_inflight();
    logic stale;
    busdata_fromhm2 = 32'hCAFEF00D;
    bus_read(16'h0234, 32'hCAFEF00D);
    bus_idle();
    drain("pre_rst");
    @(negedge reg_clk);
    chip_sel = 1; read_reg = 1; busaddress = 14'(16'h1100 >> 2);
    @(negedge reg_clk);
    chip_sel = 0; read_reg = 0; reset_reg_N = 0;
    #1;
    checks++; if (busdata_out !== 32'h0) begin failures++; $display("FAIL inflight_busdata got=%h expected=0", busdata_out); end
    checks++; if (oe_out !== '0) begin failures++; $display("FAIL inflight_oe got=%h expected=0", oe_out); end
    repeat (2) @(negedge reg_clk);
    reset_reg_N = 1;
    stale = 1'b0;
    repeat (6) begin
      @(negedge reg_clk);
      if (busdata_out !== 32'h0) stale = 1'b1;
    end
    checks++; if (stale !== 1'b0) begin failures++; $display("FAIL inflight_stale got=%b expected=0", stale); end
  endtask

  initial begin
    test_reset();
    test_ddr();
    test_mux();
    test_back_to_back();
    test_od_rw_same_edge();
    test_edge_irq();
    test_clear();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
